// File: rtl/sched_pkg.sv
// Shared types and default sizes for the bank read/write scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        RD   = 2'd0,
        WR   = 2'd1,
        TURN = 2'd2
    } mode_t;

    localparam logic TYPE_READ  = 1'b0;
    localparam logic TYPE_WRITE = 1'b1;

    localparam int DEFAULT_NUM_BANKS = 16;
    localparam int DEFAULT_REQ_SIZE  = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr, with wrap.
module rr_pick
    import sched_pkg::*;
#(
    parameter int N     = DEFAULT_NUM_BANKS,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_cand;

    // The last grant holds lowest priority, so the scan starts one above it.
    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % N);
            if (!o_found && i_req[w_cand]) begin
                o_found         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_rw_scheduler.sv
// Round-robin bank scheduler with read/write streak grouping and turnaround gaps.
// Optional grant/switch statistics counters are enabled by defining SCHED_STATS_EN.
module bank_rw_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_BANKS  = DEFAULT_NUM_BANKS,
    parameter int REQ_SIZE   = DEFAULT_REQ_SIZE,
    parameter int MAX_STREAK = 4,
    parameter int TURNAROUND = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_BANKS-1:0]               req,
    input  logic [NUM_BANKS-1:0]               req_type,
    input  logic [NUM_BANKS-1:0][REQ_SIZE-1:0] data_in,
    output logic [NUM_BANKS-1:0]               ack,
    output logic [REQ_SIZE-1:0]                data_out,
    output logic                               out_type,
    output logic                               out_valid,
    input  logic                               out_ready
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]                        rd_grant_cnt,
    output logic [15:0]                        wr_grant_cnt,
    output logic [15:0]                        switch_cnt
`endif
);

    localparam int PTR_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam int TURN_W   = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    mode_t                 r_state;
    mode_t                 r_target;
    logic [STREAK_W-1:0]   r_streak;
    logic [TURN_W-1:0]     r_turnCnt;
    logic [PTR_W-1:0]      r_rrPtr;
    logic                  r_outValid;
    logic [REQ_SIZE-1:0]   r_data;
    logic                  r_type;

    logic [NUM_BANKS-1:0]  w_rdReq;
    logic [NUM_BANKS-1:0]  w_wrReq;
    logic [NUM_BANKS-1:0]  w_cur;
    logic [NUM_BANKS-1:0]  w_oth;
    logic [NUM_BANKS-1:0]  w_onehot;
    logic [PTR_W-1:0]      w_idx;
    logic                  w_found;
    logic                  w_canGrant;
    logic                  w_active;
    logic                  w_streakOk;
    logic                  w_grant;
    logic                  w_switch;
    mode_t                 w_otherMode;

    assign w_rdReq     = req & ~req_type;
    assign w_wrReq     = req & req_type;
    assign w_cur       = (r_state == WR) ? w_wrReq : w_rdReq;
    assign w_oth       = (r_state == WR) ? w_rdReq : w_wrReq;
    assign w_otherMode = (r_state == WR) ? RD : WR;

    assign w_canGrant = !r_outValid || out_ready;
    assign w_active   = !rst && (r_state != TURN) && w_canGrant;
    assign w_streakOk = (r_streak < STREAK_W'(MAX_STREAK)) || (w_oth == '0);
    assign w_grant    = w_active && w_found && w_streakOk;
    assign w_switch   = w_active && !(w_found && w_streakOk) && (w_oth != '0);

    rr_pick #(
        .N     (NUM_BANKS),
        .IDX_W (PTR_W)
    ) u_pick (
        .i_req   (w_cur),
        .i_ptr   (r_rrPtr),
        .o_grant (w_onehot),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign ack       = w_grant ? w_onehot : '0;
    assign data_out  = r_data;
    assign out_type  = r_type;
    assign out_valid = r_outValid;

    // The cycle that decides to switch is itself the first idle cycle of the gap,
    // so TURN holds for TURNAROUND-1 cycles and is skipped when TURNAROUND is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RD;
            r_target   <= RD;
            r_streak   <= '0;
            r_turnCnt  <= '0;
            r_rrPtr    <= PTR_W'(NUM_BANKS - 1);
            r_outValid <= 1'b0;
            r_data     <= '0;
            r_type     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_data     <= data_in[w_idx];
                r_type     <= req_type[w_idx];
                r_outValid <= 1'b1;
                r_rrPtr    <= w_idx;
                if (r_streak != STREAK_W'(MAX_STREAK)) begin
                    r_streak <= r_streak + 1'b1;
                end
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end

            if (w_switch) begin
                r_target <= w_otherMode;
                if (TURNAROUND == 1) begin
                    r_state  <= w_otherMode;
                    r_streak <= '0;
                end else begin
                    r_state   <= TURN;
                    r_turnCnt <= TURN_W'(TURNAROUND - 1);
                end
            end else if (r_state == TURN) begin
                r_turnCnt <= r_turnCnt - 1'b1;
                if (r_turnCnt <= TURN_W'(1)) begin
                    r_state  <= r_target;
                    r_streak <= '0;
                end
            end
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] r_rdCnt;
    logic [15:0] r_wrCnt;
    logic [15:0] r_swCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdCnt <= '0;
            r_wrCnt <= '0;
            r_swCnt <= '0;
        end else begin
            if (w_grant && (req_type[w_idx] == TYPE_WRITE)) begin
                r_wrCnt <= r_wrCnt + 16'd1;
            end
            if (w_grant && (req_type[w_idx] == TYPE_READ)) begin
                r_rdCnt <= r_rdCnt + 16'd1;
            end
            if (w_switch) begin
                r_swCnt <= r_swCnt + 16'd1;
            end
        end
    end

    assign rd_grant_cnt = r_rdCnt;
    assign wr_grant_cnt = r_wrCnt;
    assign switch_cnt   = r_swCnt;
`endif

endmodule
